skeleton_frame_scheduler: RTL and testbench
===========================================

# skeleton_frame_scheduler

Frame-level controller in front of `skeletonizer`. It admits whole binary-mask frames from the threshold pipeline only when the skeletonizer can take a complete frame, and drops or aborts partial and overlapping frames. It tracks each admitted frame through thinning and output, and recovers a hung skeletonizer with a watchdog-driven reset. It sits between the mask stream and the skeletonizer's pixel inputs, and observes the skeletonizer's `busy` and output stream.

## Interface
Parameters:
- `HORIZONTAL_COUNT`, default 320: frame width; `HWIDTH = $clog2(HORIZONTAL_COUNT)`.
- `VERTICAL_COUNT`, default 180: frame height; `VWIDTH = $clog2(VERTICAL_COUNT)`.
- `TIMEOUT_CYCLES`, default 8_000_000: watchdog limit for one frame in WAIT_START plus RUN.
- `START_WINDOW`, default 4: maximum cycles allowed from last forwarded pixel to `sk_busy_in` rising.
- `COUNT_WIDTH`, default 16: statistics counter width.

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `enable_in` in 1: admit new frames when high.
- `hcount_in` in HWIDTH: upstream pixel column.
- `vcount_in` in VWIDTH: upstream pixel row.
- `pixel_in` in 1: upstream mask bit.
- `pixel_valid_in` in 1: upstream pixel qualifier.
- `sk_hcount_out` out HWIDTH: column forwarded to skeletonizer.
- `sk_vcount_out` out VWIDTH: row forwarded to skeletonizer.
- `sk_pixel_out` out 1: mask bit forwarded to skeletonizer.
- `sk_pixel_valid_out` out 1: forwarded-pixel qualifier.
- `sk_rst_out` out 1: reset to skeletonizer, OR-ed externally with `rst_in`.
- `sk_busy_in` in 1: skeletonizer `busy`.
- `sk_valid_in` in 1: skeletonizer `pixel_valid_out`.
- `sk_hcount_in` in HWIDTH: skeletonizer output column.
- `sk_vcount_in` in VWIDTH: skeletonizer output row.
- `frame_done_out` out 1: one-cycle pulse on completed frame.
- `timeout_out` out 1: one-cycle pulse on watchdog or start-window expiry.
- `frames_accepted_out` out COUNT_WIDTH: frames fully loaded.
- `frames_dropped_out` out COUNT_WIDTH: frames dropped or aborted.
- `state_out` out 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, LOAD=1, WAIT_START=2, RUN=3, DONE=4, RECOVER=5.
- Frame start means `pixel_valid_in` with (h,v)=(0,0).
- IDLE:
  - Frame start with `enable_in`=1 → LOAD; forward that pixel; expected coordinate becomes (1,0).
  - Frame start with `enable_in`=0 → ignored, not counted.
- LOAD: each valid input is compared with the expected raster coordinate.
  - Match: forward the pixel and advance the expected coordinate (h wraps to 0 and v increments at `HORIZONTAL_COUNT-1`).
  - Mismatch: abort. Pixel is not forwarded; `frames_dropped_out`+1; → RECOVER.
  - Matching pixel at (H-1,V-1): forward it; `frames_accepted_out`+1; → WAIT_START.
  - Gaps in `pixel_valid_in` are allowed.
  - `enable_in` falling mid-LOAD does not abort the frame.
- WAIT_START:
  - `sk_busy_in`=1 → RUN.
  - `START_WINDOW` cycles elapsed without busy → `timeout_out` pulse, → RECOVER.
- RUN:
  - `sk_valid_in` with (H-1,V-1) → DONE.
  - Watchdog reaching `TIMEOUT_CYCLES` → `timeout_out` pulse, → RECOVER.
- DONE: `frame_done_out`=1 for this cycle; → IDLE.
- RECOVER: `sk_rst_out`=1 for exactly 2 cycles; → IDLE.
- Frame start seen in LOAD (as mismatch), WAIT_START, RUN, DONE or RECOVER: `frames_dropped_out`+1, regardless of `enable_in`. Such pixels are never forwarded.
- Counters saturate at all-ones; no wrap.
- Watchdog:
  - Cleared on entry to WAIT_START.
  - Increments every cycle in WAIT_START and RUN.
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
- Simultaneous events:
  - Timeout and last output pixel in the same cycle → DONE wins; no `timeout_out`.
  - Drop and accept never coincide.

## Timing
- Forward path registered: input valid at cycle t appears on `sk_*_out` at t+1. No combinational path from input to output.
- `sk_pixel_valid_out` is low outside LOAD-forwarded cycles.
- State transitions take effect on the clock edge after the triggering input.
- `frame_done_out` rises one cycle after the last skeleton output pixel is sampled.
- `sk_rst_out` is high during the two cycles following the abort or timeout edge.
- Reset values: state IDLE; all `sk_*_out`=0; `sk_rst_out`=0; pulses=0; both counters=0; watchdog=0; expected coordinate (0,0).
- `rst_in` mid-frame returns to IDLE immediately and does not assert `sk_rst_out`; the external OR resets the skeletonizer.

## Test plan
- Full 320×180 frame, contiguous valid, model skeletonizer raises busy 2 cycles after last pixel, outputs (319,179) later → 57600 pixels forwarded at +1 latency, accepted=1, single `frame_done_out`, state back to 0.
- Second frame start while in RUN → no pixels forwarded, dropped=1, first frame still completes.
- Coordinate skip in LOAD (e.g. (5,0) after (3,0)) → dropped=1, `sk_rst_out` high exactly 2 cycles, IDLE; next clean frame accepted.
- Busy never rises → `timeout_out` pulse 4 cycles after last forward, RECOVER, IDLE.
- `TIMEOUT_CYCLES`=100, busy held high with no output → `timeout_out` at cycle 100 of RUN; a last output pixel arriving on the timeout cycle yields DONE only.
- `enable_in`=0 with frame start → ignored, counters 0; `rst_in` during LOAD → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/skeleton_frame_scheduler.sv
// skeleton_frame_scheduler: admits whole mask frames into the skeletonizer, tracks each one to completion
// and recovers a hung skeletonizer through a watchdog-driven local reset.
module skeleton_frame_scheduler #(
   parameter int HORIZONTAL_COUNT = 320,
   parameter int VERTICAL_COUNT = 180,
   parameter int TIMEOUT_CYCLES = 8_000_000,
   parameter int START_WINDOW = 4,
   parameter int COUNT_WIDTH = 16,
   localparam int HWIDTH = $clog2(HORIZONTAL_COUNT),
   localparam int VWIDTH = $clog2(VERTICAL_COUNT)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   enable_in,
   input  logic [HWIDTH-1:0]      hcount_in,
   input  logic [VWIDTH-1:0]      vcount_in,
   input  logic                   pixel_in,
   input  logic                   pixel_valid_in,
   output logic [HWIDTH-1:0]      sk_hcount_out,
   output logic [VWIDTH-1:0]      sk_vcount_out,
   output logic                   sk_pixel_out,
   output logic                   sk_pixel_valid_out,
   output logic                   sk_rst_out,
   input  logic                   sk_busy_in,
   input  logic                   sk_valid_in,
   input  logic [HWIDTH-1:0]      sk_hcount_in,
   input  logic [VWIDTH-1:0]      sk_vcount_in,
   output logic                   frame_done_out,
   output logic                   timeout_out,
   output logic [COUNT_WIDTH-1:0] frames_accepted_out,
   output logic [COUNT_WIDTH-1:0] frames_dropped_out,
   output logic [2:0]             state_out
);
   localparam int WWIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT_START = 3'd2, RUN = 3'd3, DONE = 3'd4, RECOVER = 3'd5;
   localparam logic [HWIDTH-1:0] H_LAST = HWIDTH'(HORIZONTAL_COUNT - 1);
   localparam logic [VWIDTH-1:0] V_LAST = VWIDTH'(VERTICAL_COUNT - 1);
   localparam logic [WWIDTH-1:0] WD_START = WWIDTH'(START_WINDOW - 1);
   localparam logic [WWIDTH-1:0] WD_LIMIT = WWIDTH'(TIMEOUT_CYCLES - 1);

   logic [2:0] state, state_nxt;
   logic [HWIDTH-1:0] exp_h, exp_h_nxt;
   logic [VWIDTH-1:0] exp_v, exp_v_nxt;
   logic [WWIDTH-1:0] wd;
   logic rec_second, frame_start, match, last_in, last_out, fwd, accept, drop, expire;

   assign frame_start = pixel_valid_in && hcount_in == '0 && vcount_in == '0;
   assign match = pixel_valid_in && hcount_in == exp_h && vcount_in == exp_v;
   assign last_in = match && exp_h == H_LAST && exp_v == V_LAST;
   assign last_out = sk_valid_in && sk_hcount_in == H_LAST && sk_vcount_in == V_LAST;
   assign fwd = (state == IDLE && frame_start && enable_in) || (state == LOAD && match);
   assign accept = state == LOAD && last_in;
   assign drop = state == LOAD ? pixel_valid_in && !match : state != IDLE && frame_start;
   // the last output pixel outranks the watchdog when both land in the same RUN cycle
   assign expire = (state == WAIT_START && !sk_busy_in && wd == WD_START) ||
                   (state == RUN && !last_out && wd == WD_LIMIT);
   assign exp_h_nxt = exp_h == H_LAST ? '0 : exp_h + 1'b1;
   assign exp_v_nxt = exp_h != H_LAST ? exp_v : exp_v == V_LAST ? '0 : exp_v + 1'b1;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       state_nxt = fwd ? LOAD : IDLE;
         LOAD:       state_nxt = drop ? RECOVER : accept ? WAIT_START : LOAD;
         WAIT_START: state_nxt = sk_busy_in ? RUN : expire ? RECOVER : WAIT_START;
         RUN:        state_nxt = last_out ? DONE : expire ? RECOVER : RUN;
         DONE:       state_nxt = IDLE;
         RECOVER:    state_nxt = rec_second ? IDLE : RECOVER;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         exp_h <= '0;
         exp_v <= '0;
         wd <= '0;
         rec_second <= 1'b0;
         sk_hcount_out <= '0;
         sk_vcount_out <= '0;
         sk_pixel_out <= 1'b0;
         sk_pixel_valid_out <= 1'b0;
         timeout_out <= 1'b0;
         frames_accepted_out <= '0;
         frames_dropped_out <= '0;
      end else begin
         state <= state_nxt;
         exp_h <= fwd ? exp_h_nxt : state == LOAD ? exp_h : '0;
         exp_v <= fwd ? exp_v_nxt : state == LOAD ? exp_v : '0;
         wd <= (state == WAIT_START || state == RUN) ? wd + 1'b1 : '0;
         rec_second <= state == RECOVER && !rec_second;
         sk_pixel_valid_out <= fwd;
         if (fwd) begin
            sk_hcount_out <= hcount_in;
            sk_vcount_out <= vcount_in;
            sk_pixel_out <= pixel_in;
         end
         timeout_out <= expire;
         if (accept && !(&frames_accepted_out)) frames_accepted_out <= frames_accepted_out + 1'b1;
         if (drop && !(&frames_dropped_out)) frames_dropped_out <= frames_dropped_out + 1'b1;
      end
   end

   assign sk_rst_out = state == RECOVER;
   assign frame_done_out = state == DONE;
   assign state_out = state;
endmodule

// File: tb/tb_skeleton_frame_scheduler.sv
// tb_skeleton_frame_scheduler: directed vectors on a 4x2 instance plus a full 320x180 frame on a default-size instance.
module tb_skeleton_frame_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int tests = 0, fails = 0;

   logic s_rst = 1'b1, s_en = 1'b0, s_pv = 1'b0, s_pix = 1'b0, s_busy = 1'b0, s_skv = 1'b0;
   logic [1:0] s_h = '0, s_skh = '0;
   logic s_v = 1'b0, s_skvv = 1'b0;
   logic [1:0] s_oh;
   logic s_ov, s_opix, s_ofv, s_rs, s_dn, s_to;
   logic [2:0] s_acc, s_drp, s_st;

   skeleton_frame_scheduler #(.HORIZONTAL_COUNT(4), .VERTICAL_COUNT(2), .TIMEOUT_CYCLES(100),
                              .START_WINDOW(4), .COUNT_WIDTH(3)) u_small (
      .clk_in(clk), .rst_in(s_rst), .enable_in(s_en), .hcount_in(s_h), .vcount_in(s_v),
      .pixel_in(s_pix), .pixel_valid_in(s_pv), .sk_hcount_out(s_oh), .sk_vcount_out(s_ov),
      .sk_pixel_out(s_opix), .sk_pixel_valid_out(s_ofv), .sk_rst_out(s_rs), .sk_busy_in(s_busy),
      .sk_valid_in(s_skv), .sk_hcount_in(s_skh), .sk_vcount_in(s_skvv), .frame_done_out(s_dn),
      .timeout_out(s_to), .frames_accepted_out(s_acc), .frames_dropped_out(s_drp), .state_out(s_st));

   logic b_rst = 1'b1, b_en = 1'b0, b_pv = 1'b0, b_pix = 1'b0, b_busy = 1'b0, b_skv = 1'b0;
   logic [8:0] b_h = '0, b_skh = '0, b_oh;
   logic [7:0] b_v = '0, b_skvv = '0, b_ov;
   logic b_opix, b_ofv, b_rs, b_dn, b_to;
   logic [15:0] b_acc, b_drp;
   logic [2:0] b_st;
   int b_fwd_cnt = 0, b_done_cnt = 0;

   skeleton_frame_scheduler u_big (
      .clk_in(clk), .rst_in(b_rst), .enable_in(b_en), .hcount_in(b_h), .vcount_in(b_v),
      .pixel_in(b_pix), .pixel_valid_in(b_pv), .sk_hcount_out(b_oh), .sk_vcount_out(b_ov),
      .sk_pixel_out(b_opix), .sk_pixel_valid_out(b_ofv), .sk_rst_out(b_rs), .sk_busy_in(b_busy),
      .sk_valid_in(b_skv), .sk_hcount_in(b_skh), .sk_vcount_in(b_skvv), .frame_done_out(b_dn),
      .timeout_out(b_to), .frames_accepted_out(b_acc), .frames_dropped_out(b_drp), .state_out(b_st));

   always @(posedge clk) begin
      if (b_ofv) b_fwd_cnt <= b_fwd_cnt + 1;
      if (b_dn) b_done_cnt <= b_done_cnt + 1;
   end

   typedef struct {
      logic rst, en, pv; logic [1:0] h; logic v; logic pix, busy, skv; logic [1:0] skh; logic skvv;
      logic [2:0] st; logic fv; logic [1:0] fh; logic fvv; logic fpix, rs, dn, to; logic [2:0] acc, drp;
   } vec_t;
   vec_t vt [0:37];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic load_small();
      for (int i = 0; i < 8; i++) begin
         s_en = 1'b1;
         s_pv = 1'b1;
         s_h = 2'(i % 4);
         s_v = 1'(i / 4);
         s_pix = 1'(i);
         tick();
      end
      s_pv = 1'b0;
   endtask

   initial begin
      int n, bad;
      logic [63:0] got, exp;
      //         rst en pv h v pix bsy skv skh skv | st fv fh fv fpx rs dn to acc drp
      vt[0]  = '{1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0};
      vt[1]  = '{0,0,1,0,0,1,0,0,0,0, 0,0,0,0,0,0,0,0,0,0};
      vt[2]  = '{0,1,1,0,0,1,0,0,0,0, 1,1,0,0,1,0,0,0,0,0};
      vt[3]  = '{0,0,1,1,0,0,0,0,0,0, 1,1,1,0,0,0,0,0,0,0};
      vt[4]  = '{0,1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0};
      vt[5]  = '{0,1,1,2,0,1,0,0,0,0, 1,1,2,0,1,0,0,0,0,0};
      vt[6]  = '{0,1,1,3,0,0,0,0,0,0, 1,1,3,0,0,0,0,0,0,0};
      vt[7]  = '{0,1,1,0,1,1,0,0,0,0, 1,1,0,1,1,0,0,0,0,0};
      vt[8]  = '{0,1,1,1,1,1,0,0,0,0, 1,1,1,1,1,0,0,0,0,0};
      vt[9]  = '{0,1,1,2,1,0,0,0,0,0, 1,1,2,1,0,0,0,0,0,0};
      vt[10] = '{0,1,1,3,1,1,0,0,0,0, 2,1,3,1,1,0,0,0,1,0};
      vt[11] = '{0,1,0,0,0,0,0,0,0,0, 2,0,0,0,0,0,0,0,1,0};
      vt[12] = '{0,1,0,0,0,0,1,0,0,0, 3,0,0,0,0,0,0,0,1,0};
      vt[13] = '{0,1,1,0,0,1,1,0,0,0, 3,0,0,0,0,0,0,0,1,1};
      vt[14] = '{0,1,0,0,0,0,1,1,3,0, 3,0,0,0,0,0,0,0,1,1};
      vt[15] = '{0,1,0,0,0,0,0,1,3,1, 4,0,0,0,0,0,1,0,1,1};
      vt[16] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,1};
      vt[17] = '{0,1,1,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,1,1};
      vt[18] = '{0,1,1,1,0,1,0,0,0,0, 1,1,1,0,1,0,0,0,1,1};
      vt[19] = '{0,1,1,3,0,1,0,0,0,0, 5,0,0,0,0,1,0,0,1,2};
      vt[20] = '{0,1,1,0,0,1,0,0,0,0, 5,0,0,0,0,1,0,0,1,3};
      vt[21] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1,3};
      vt[22] = '{0,1,1,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,1,3};
      vt[23] = '{0,1,1,1,0,1,0,0,0,0, 1,1,1,0,1,0,0,0,1,3};
      vt[24] = '{0,1,1,2,0,0,0,0,0,0, 1,1,2,0,0,0,0,0,1,3};
      vt[25] = '{0,1,1,3,0,1,0,0,0,0, 1,1,3,0,1,0,0,0,1,3};
      vt[26] = '{0,1,1,0,1,0,0,0,0,0, 1,1,0,1,0,0,0,0,1,3};
      vt[27] = '{0,1,1,1,1,1,0,0,0,0, 1,1,1,1,1,0,0,0,1,3};
      vt[28] = '{0,1,1,2,1,0,0,0,0,0, 1,1,2,1,0,0,0,0,1,3};
      vt[29] = '{0,1,1,3,1,1,0,0,0,0, 2,1,3,1,1,0,0,0,2,3};
      vt[30] = '{0,0,0,0,0,0,0,0,0,0, 2,0,0,0,0,0,0,0,2,3};
      vt[31] = '{0,0,0,0,0,0,0,0,0,0, 2,0,0,0,0,0,0,0,2,3};
      vt[32] = '{0,0,0,0,0,0,0,0,0,0, 2,0,0,0,0,0,0,0,2,3};
      vt[33] = '{0,0,0,0,0,0,0,0,0,0, 5,0,0,0,0,1,0,1,2,3};
      vt[34] = '{0,0,0,0,0,0,0,0,0,0, 5,0,0,0,0,1,0,0,2,3};
      vt[35] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,2,3};
      vt[36] = '{0,1,1,0,0,1,0,0,0,0, 1,1,0,0,1,0,0,0,2,3};
      vt[37] = '{1,0,1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0};
      tick();
      b_rst = 1'b0;
      for (int i = 0; i < 38; i++) begin
         {s_rst, s_en, s_pv, s_h, s_v, s_pix, s_busy, s_skv, s_skh, s_skvv} =
            {vt[i].rst, vt[i].en, vt[i].pv, vt[i].h, vt[i].v, vt[i].pix, vt[i].busy, vt[i].skv, vt[i].skh, vt[i].skvv};
         tick();
         got = {s_st, s_ofv, s_rs, s_dn, s_to, s_acc, s_drp, s_ofv ? {s_oh, s_ov, s_opix} : 4'b0};
         exp = {vt[i].st, vt[i].fv, vt[i].rs, vt[i].dn, vt[i].to, vt[i].acc, vt[i].drp,
                vt[i].fv ? {vt[i].fh, vt[i].fvv, vt[i].fpix} : 4'b0};
         check($sformatf("vec%0d", i), got, exp);
      end
      check("rst_fwd_regs", {s_oh, s_ov, s_opix}, 0);
      s_rst = 1'b0;
      s_pv = 1'b0;
      load_small();
      s_busy = 1'b1;
      n = 0;
      while (!s_to && n < 200) begin
         tick();
         n++;
      end
      check("run_timeout_cycle", n, 100);
      check("run_timeout_state", s_st, 5);
      s_busy = 1'b0;
      tick();
      tick();
      check("recover_exit", {s_st, s_rs}, 0);
      load_small();
      s_busy = 1'b1;
      repeat (99) tick();
      check("tie_pre_state", {s_st, s_to}, {3'd3, 1'b0});
      {s_skv, s_skh, s_skvv} = {1'b1, 2'd3, 1'b1};
      tick();
      check("tie_done_only", {s_st, s_dn, s_to}, {3'd4, 1'b1, 1'b0});
      {s_skv, s_busy} = 2'b00;
      tick();
      check("tie_idle", s_st, 0);
      for (int k = 1; k <= 8; k++) begin
         {s_en, s_pv, s_h, s_v} = {1'b1, 1'b1, 2'd0, 1'b0};
         tick();
         s_h = 2'd2;
         tick();
         s_pv = 1'b0;
         tick();
         tick();
         if (k >= 7) check($sformatf("drop_sat%0d", k), s_drp, 7);
      end
      check("acc_after_aborts", {s_acc, s_st}, {3'd2, 3'd0});

      b_en = 1'b1;
      bad = 0;
      for (int v = 0; v < 180; v++) begin
         for (int h = 0; h < 320; h++) begin
            {b_pv, b_h, b_v, b_pix} = {1'b1, 9'(h), 8'(v), 1'(h ^ v)};
            tick();
            if (!(b_ofv && b_oh == 9'(h) && b_ov == 8'(v) && b_opix == b_pix)) bad++;
         end
      end
      b_pv = 1'b0;
      check("big_stream_errors", bad, 0);
      check("big_accept", {b_acc, b_st}, {16'd1, 3'd2});
      tick();
      b_busy = 1'b1;
      tick();
      check("big_run", b_st, 3);
      {b_pv, b_h, b_v} = {1'b1, 9'd0, 8'd0};
      tick();
      b_pv = 1'b0;
      check("big_drop_in_run", {b_ofv, b_drp, b_st}, {1'b0, 16'd1, 3'd3});
      repeat (3) tick();
      {b_skv, b_skh, b_skvv} = {1'b1, 9'd319, 8'd179};
      tick();
      {b_skv, b_busy} = 2'b00;
      check("big_done", {b_dn, b_st, b_to}, {1'b1, 3'd4, 1'b0});
      tick();
      tick();
      check("big_idle", b_st, 0);
      check("big_fwd_count", b_fwd_cnt, 57600);
      check("big_done_count", b_done_cnt, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
